// File: rtl/prog_mod_n_cnt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prog_mod_n_cnt_pkg
// Brief    : Shared types for the programmable modulo counter (count mode
//            and direction encodings).
// Revision : 1.0 - initial release
// ============================================================================
package prog_mod_n_cnt_pkg;

  // Counting mode presented on i_mode
  typedef enum logic [1:0] {
    MODE_UP       = 2'b00,
    MODE_DOWN     = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_HOLD     = 2'b11
  } mode_e;

  // Direction state, also visible on o_dir
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage : prog_mod_n_cnt_pkg
`default_nettype wire

// File: rtl/prog_mod_n_cnt_step.sv
`default_nettype none
// ============================================================================
// Module   : prog_mod_n_cnt_step
// Brief    : Combinational step function of the modulo counter. Given the
//            present count, direction, mode and terminal value it produces
//            the next count, next direction and a wrap flag (wrap, bounce
//            or out-of-range recovery on this step).
// Revision : 1.0 - initial release
// ============================================================================
module prog_mod_n_cnt_step
  import prog_mod_n_cnt_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] nxt_q,
  output logic             nxt_dir,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] C_ZERO = '0;
  localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  mode_e w_mode;
  logic  w_max_zero;
  logic  w_at_top;
  logic  w_at_bot;
  logic  w_over;

  assign w_mode     = mode_e'(mode);
  assign w_max_zero = (max_val == C_ZERO);
  assign w_at_top   = (q == max_val);
  assign w_at_bot   = (q == C_ZERO);
  assign w_over     = (q > max_val);

  // Next count / direction for one enabled step in the selected mode
  always_comb begin
    nxt_q   = q;
    nxt_dir = dir;
    wrap    = 1'b0;
    if (w_mode == MODE_HOLD) begin
      nxt_q = q;
    end else if (w_max_zero) begin
      // Modulus one: pinned at zero, every step counts as a wrap
      nxt_q = C_ZERO;
      wrap  = 1'b1;
    end else begin
      case (w_mode)
        MODE_UP: begin
          nxt_dir = DIR_UP;
          if (w_at_top || w_over) begin
            nxt_q = C_ZERO;
            wrap  = 1'b1;
          end else begin
            nxt_q = q + C_ONE;
          end
        end
        MODE_DOWN: begin
          nxt_dir = DIR_DOWN;
          if (w_at_bot || w_over) begin
            nxt_q = max_val;
            wrap  = 1'b1;
          end else begin
            nxt_q = q - C_ONE;
          end
        end
        MODE_PINGPONG: begin
          if (dir == DIR_UP) begin
            if (w_over) begin
              // Recovery from a shrunk terminal value also turns around
              nxt_q   = C_ZERO;
              nxt_dir = DIR_DOWN;
              wrap    = 1'b1;
            end else if (w_at_top) begin
              nxt_q   = q - C_ONE;
              nxt_dir = DIR_DOWN;
              wrap    = 1'b1;
            end else begin
              nxt_q = q + C_ONE;
            end
          end else begin
            if (w_over) begin
              nxt_q = max_val;
              wrap  = 1'b1;
            end else if (w_at_bot) begin
              nxt_q   = C_ONE;
              nxt_dir = DIR_UP;
              wrap    = 1'b1;
            end else begin
              nxt_q = q - C_ONE;
            end
          end
        end
        default: begin
          nxt_q = q;
        end
      endcase
    end
  end

endmodule : prog_mod_n_cnt_step
`default_nettype wire

// File: rtl/prog_mod_n_counter.sv
`default_nettype none
// ============================================================================
// Module   : prog_mod_n_counter
// Brief    : Runtime-programmable modulo counter with UP / DOWN / PINGPONG /
//            HOLD modes, clamped synchronous load and a combinational
//            terminal-count output for cascading.
//            Optional build macro PROG_MOD_N_WRAP_CNT_EN adds a saturating
//            wrap-event counter (ports i_clr_stat, o_wrap_cnt).
// Revision : 1.0 - initial release
// ============================================================================
module prog_mod_n_counter
  import prog_mod_n_cnt_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int RST_VAL    = 0,
  parameter int WRAP_CNT_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [1:0]            i_mode,
  input  logic [WIDTH-1:0]      i_max,
  input  logic                  i_load,
  input  logic [WIDTH-1:0]      i_load_val,
`ifdef PROG_MOD_N_WRAP_CNT_EN
  input  logic                  i_clr_stat,
  output logic [WRAP_CNT_W-1:0] o_wrap_cnt,
`endif
  output logic [WIDTH-1:0]      o_q,
  output logic                  o_dir,
  output logic                  o_tc
);

  localparam logic [WIDTH-1:0] C_RST_Q = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] r_q;
  dir_e             r_dir;

  logic [WIDTH-1:0] w_step_q;
  logic             w_step_dir;
  logic             w_step_wrap;
  logic [WIDTH-1:0] w_load_q;
  logic             w_step_en;
  logic [WIDTH-1:0] w_q_nxt;
  dir_e             w_dir_nxt;

  prog_mod_n_cnt_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .q       (r_q),
    .dir     (r_dir),
    .mode    (i_mode),
    .max_val (i_max),
    .nxt_q   (w_step_q),
    .nxt_dir (w_step_dir),
    .wrap    (w_step_wrap)
  );

  // Load value never exceeds the current terminal value
  assign w_load_q  = (i_load_val > i_max) ? i_max : i_load_val;
  assign w_step_en = i_en && (mode_e'(i_mode) != MODE_HOLD);

  // Priority: load, then enabled step, otherwise hold
  always_comb begin
    w_q_nxt   = r_q;
    w_dir_nxt = r_dir;
    if (i_load) begin
      w_q_nxt = w_load_q;
    end else if (w_step_en) begin
      w_q_nxt   = w_step_q;
      w_dir_nxt = dir_e'(w_step_dir);
    end
  end

  // Count and direction state registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q   <= C_RST_Q;
      r_dir <= DIR_UP;
    end else begin
      r_q   <= w_q_nxt;
      r_dir <= w_dir_nxt;
    end
  end

  assign o_q   = r_q;
  assign o_dir = r_dir;
  assign o_tc  = w_step_en && !i_load && w_step_wrap;

`ifdef PROG_MOD_N_WRAP_CNT_EN
  logic [WRAP_CNT_W-1:0] r_wrap_cnt;

  // Saturating count of terminal-count cycles; clear beats increment
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wrap_cnt <= '0;
    end else if (i_clr_stat) begin
      r_wrap_cnt <= '0;
    end else if (o_tc && (r_wrap_cnt != {WRAP_CNT_W{1'b1}})) begin
      r_wrap_cnt <= r_wrap_cnt + {{(WRAP_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_wrap_cnt = r_wrap_cnt;
`endif

endmodule : prog_mod_n_counter
`default_nettype wire

// File: tb/tb_prog_mod_n_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_mod_n_counter
// Brief    : Self-checking bench: directed scenarios with literal expectations
//            plus randomized traffic compared every cycle against an
//            arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_mod_n_counter;

  localparam int WIDTH = 4;
  localparam int WCW   = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             load = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic [WIDTH-1:0] mx = '0;
  logic [WIDTH-1:0] lv = '0;
  logic [WIDTH-1:0] o_q;
  logic             o_dir;
  logic             o_tc;
`ifdef PROG_MOD_N_WRAP_CNT_EN
  logic             clr = 1'b0;
  logic [WCW-1:0]   wcnt;
`endif

  prog_mod_n_counter #(
    .WIDTH      (WIDTH),
    .RST_VAL    (0),
    .WRAP_CNT_W (WCW)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_mode     (mode),
    .i_max      (mx),
    .i_load     (load),
    .i_load_val (lv),
`ifdef PROG_MOD_N_WRAP_CNT_EN
    .i_clr_stat (clr),
    .o_wrap_cnt (wcnt),
`endif
    .o_q        (o_q),
    .o_dir      (o_dir),
    .o_tc       (o_tc)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit run_cmp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: one enabled step computed from the mode rules with integers
  function automatic void mstep(input int q, input int d, input int md, input int m,
                                output int nq, output int nd, output int t);
    nq = q; nd = d; t = 0;
    if (md == 3) return;
    if (m == 0) begin nq = 0; t = 1; return; end
    if (md == 0) begin
      nd = 1;
      if (q >= m) begin nq = 0; t = 1; end else nq = q + 1;
    end else if (md == 1) begin
      nd = 0;
      if (q == 0 || q > m) begin nq = m; t = 1; end else nq = q - 1;
    end else if (d == 1) begin
      if (q > m)       begin nq = 0;     nd = 0; t = 1; end
      else if (q == m) begin nq = q - 1; nd = 0; t = 1; end
      else nq = q + 1;
    end else begin
      if (q > m)       begin nq = m;           t = 1; end
      else if (q == 0) begin nq = 1;     nd = 1; t = 1; end
      else nq = q - 1;
    end
  endfunction

  int m_q = 0, m_dir = 1, m_wc = 0;

  function automatic int model_tc();
    int nq, nd, t;
    mstep(m_q, m_dir, int'(mode), int'(mx), nq, nd, t);
    return (en && !load && mode != 2'd3 && t == 1) ? 1 : 0;
  endfunction

  // Model state advance, mirroring the asynchronous reset
  always @(posedge clk or posedge rst) begin
    int nq, nd, t, tc;
    if (rst) begin
      m_q = 0; m_dir = 1; m_wc = 0;
    end else begin
      tc = model_tc();
`ifdef PROG_MOD_N_WRAP_CNT_EN
      if (clr) m_wc = 0;
      else if (tc == 1 && m_wc < (1 << WCW) - 1) m_wc = m_wc + 1;
`endif
      if (load) begin
        m_q = (int'(lv) > int'(mx)) ? int'(mx) : int'(lv);
      end else if (en && mode != 2'd3) begin
        mstep(m_q, m_dir, int'(mode), int'(mx), nq, nd, t);
        m_q = nq; m_dir = nd;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("cmp_q", 32'(o_q), 32'(m_q));
      chk("cmp_dir", 32'(o_dir), 32'(m_dir));
      chk("cmp_tc", 32'(o_tc), 32'(model_tc()));
`ifdef PROG_MOD_N_WRAP_CNT_EN
      chk("cmp_wcnt", 32'(wcnt), 32'(m_wc));
`endif
    end
  end

  task automatic drv(input logic e, input logic [1:0] m, input logic [3:0] x,
                     input logic l, input logic [3:0] v);
    @(posedge clk);
    #2;
    en = e; mode = m; mx = x; load = l; lv = v;
  endtask

  task automatic pk();
    @(negedge clk);
    #1;
  endtask

  int t1q [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
  int t2q [7]  = '{0, 5, 4, 3, 2, 1, 0};
  int t3q [7]  = '{0, 1, 2, 3, 2, 1, 0};
  int t3tc[7]  = '{0, 0, 0, 1, 0, 0, 1};

  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    run_cmp = 1'b1;
    pk();
    chk("reset_q", 32'(o_q), 32'd0);
    chk("reset_dir", 32'(o_dir), 32'd1);

    // UP, terminal 9
    for (int i = 0; i < 12; i++) begin
      drv(1'b1, 2'd0, 4'd9, 1'b0, 4'd0);
      pk();
      chk("up_q", 32'(o_q), 32'(t1q[i]));
      chk("up_tc", 32'(o_tc), (t1q[i] == 9) ? 32'd1 : 32'd0);
    end
    drv(1'b0, 2'd0, 4'd9, 1'b0, 4'd0);
    pk();
    chk("up_end_q", 32'(o_q), 32'd2);

    // DOWN, terminal 5, starting from 0
    drv(1'b0, 2'd1, 4'd5, 1'b1, 4'd0);
    for (int i = 0; i < 7; i++) begin
      drv(1'b1, 2'd1, 4'd5, 1'b0, 4'd0);
      pk();
      chk("down_q", 32'(o_q), 32'(t2q[i]));
      chk("down_tc", 32'(o_tc), (t2q[i] == 0) ? 32'd1 : 32'd0);
    end
    drv(1'b0, 2'd1, 4'd5, 1'b0, 4'd0);
    pk();
    chk("down_end_q", 32'(o_q), 32'd5);
    chk("down_dir", 32'(o_dir), 32'd0);

    // PINGPONG, terminal 3, from reset
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drv(1'b1, 2'd2, 4'd3, 1'b0, 4'd0);
      pk();
      chk("pp_q", 32'(o_q), 32'(t3q[i]));
      chk("pp_tc", 32'(o_tc), 32'(t3tc[i]));
    end
    drv(1'b0, 2'd2, 4'd3, 1'b0, 4'd0);
    pk();
    chk("pp_end_q", 32'(o_q), 32'd1);
    chk("pp_end_dir", 32'(o_dir), 32'd1);

    // Load clamp and load priority
    drv(1'b0, 2'd0, 4'd7, 1'b1, 4'd12);
    pk();
    chk("load_tc", 32'(o_tc), 32'd0);
    drv(1'b0, 2'd0, 4'd7, 1'b0, 4'd0);
    pk();
    chk("load_clamp_q", 32'(o_q), 32'd7);
    drv(1'b1, 2'd0, 4'd7, 1'b1, 4'd3);
    pk();
    chk("load_en_tc", 32'(o_tc), 32'd0);
    drv(1'b0, 2'd0, 4'd7, 1'b0, 4'd0);
    pk();
    chk("load_wins_q", 32'(o_q), 32'd3);

    // Shrunk terminal value, then modulus one
    drv(1'b0, 2'd0, 4'd15, 1'b1, 4'd9);
    drv(1'b1, 2'd0, 4'd4, 1'b0, 4'd0);
    pk();
    chk("oor_q", 32'(o_q), 32'd9);
    chk("oor_tc", 32'(o_tc), 32'd1);
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, 2'd0, 4'd0, 1'b0, 4'd0);
      pk();
      chk("max0_q", 32'(o_q), 32'd0);
      chk("max0_tc", 32'(o_tc), 32'd1);
    end

    // Asynchronous reset between edges mid-PINGPONG
    drv(1'b0, 2'd2, 4'd3, 1'b1, 4'd3);
    drv(1'b1, 2'd2, 4'd3, 1'b0, 4'd0);
    drv(1'b1, 2'd2, 4'd3, 1'b0, 4'd0);
    pk();
    chk("pre_rst_q", 32'(o_q), 32'd2);
    chk("pre_rst_dir", 32'(o_dir), 32'd0);
    rst = 1'b1;
    #1;
    chk("async_rst_q", 32'(o_q), 32'd0);
    chk("async_rst_dir", 32'(o_dir), 32'd1);
    @(posedge clk); #2 rst = 1'b0;
    pk();
    chk("rst_release_q", 32'(o_q), 32'd0);

`ifdef PROG_MOD_N_WRAP_CNT_EN
    // Wrap counter saturation and clear
    for (int i = 0; i < 300; i++) drv(1'b1, 2'd0, 4'd0, 1'b0, 4'd0);
    drv(1'b0, 2'd0, 4'd0, 1'b0, 4'd0);
    pk();
    chk("wcnt_sat", 32'(wcnt), 32'd255);
    drv(1'b1, 2'd0, 4'd0, 1'b0, 4'd0);
    clr = 1'b1;
    drv(1'b0, 2'd0, 4'd0, 1'b0, 4'd0);
    clr = 1'b0;
    pk();
    chk("wcnt_clr", 32'(wcnt), 32'd0);
`endif

    // Randomized traffic, checked by the per-cycle compare process
    for (int i = 0; i < 800; i++) begin
      @(posedge clk);
      #2;
      en   = ($urandom_range(0, 3) != 0);
      mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) mx = 4'($urandom_range(0, 15));
      load = ($urandom_range(0, 7) == 0);
      lv   = 4'($urandom_range(0, 15));
`ifdef PROG_MOD_N_WRAP_CNT_EN
      clr  = ($urandom_range(0, 31) == 0);
`endif
    end
    pk();

    run_cmp = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_prog_mod_n_counter
`default_nettype wire
